// File: rtl/vec_mul_lanes_if.sv
// vec_mul_lanes_if: operand/result handshake bundle for the lane-parallel multiplier.
// Carries the input valid/ready/operands and the output valid/ready/products.
// The out_sum member exists only when VEC_MUL_SUM_EN is defined.
interface vec_mul_lanes_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_signed;
  logic [LANES*WIDTH-1:0]     in_a;
  logic [LANES*WIDTH-1:0]     in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*2*WIDTH-1:0]   product;
`ifdef VEC_MUL_SUM_EN
  localparam int SUM_W = 2*WIDTH + $clog2(LANES) + 1;
  logic [SUM_W-1:0]           out_sum;
`endif

  // Upstream/downstream environment side: drives operands and out_ready.
  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, product
`ifdef VEC_MUL_SUM_EN
    , input out_sum
`endif
  );

  // Multiplier side: consumes operands, produces results.
  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, product
`ifdef VEC_MUL_SUM_EN
    , output out_sum
`endif
  );
endinterface

// File: rtl/vec_mul_lanes.sv
// vec_mul_lanes: LANES independent WIDTH x WIDTH multipliers, signed or unsigned per
// transaction, in a STAGES-deep valid/ready pipeline. Slot 1 registers the full
// products, the remaining slots are pure delay. The whole pipe freezes while the
// output holds valid data that downstream refuses.
// Optional feature macro: VEC_MUL_SUM_EN adds out_sum, the sum of the lane products,
// registered in the last slot from slot STAGES-1 (requires STAGES >= 2).
module vec_mul_lanes #(
  parameter int LANES  = 4,
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  vec_mul_lanes_if.slave bus
);
  localparam int PW = 2*WIDTH;
  localparam int PV = LANES*PW;

  logic [STAGES-1:0] valid_q;
  logic [PV-1:0]     data_q [STAGES];
  logic [PV-1:0]     lane_prod;
  logic              stall;
  logic              accept;

  assign stall        = valid_q[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.product   = data_q[STAGES-1];

  // Per-lane operand extension; truncating the 2W-bit product of the extended
  // operands gives the exact signed or unsigned result.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [PW-1:0]    ext_a;
    logic [PW-1:0]    ext_b;
    assign a     = bus.in_a[i*WIDTH +: WIDTH];
    assign b     = bus.in_b[i*WIDTH +: WIDTH];
    assign ext_a = bus.in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign ext_b = bus.in_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign lane_prod[i*PW +: PW] = ext_a * ext_b;
  end

  // Pipeline slots: bubbles advance but leave data untouched so product keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) data_q[0] <= lane_prod;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

`ifdef VEC_MUL_SUM_EN
  localparam int SUM_W = PW + $clog2(LANES) + 1;

  if (STAGES < 2) begin : g_bad_stages
    $error("vec_mul_lanes: VEC_MUL_SUM_EN needs STAGES >= 2");
  end

  // The mode bit only matters until the sum is formed, so the last slot does not keep it.
  logic [STAGES-2:0] mode_q;
  logic [SUM_W-1:0]  lane_ext [LANES];
  logic [SUM_W-1:0]  sum_next;
  logic [SUM_W-1:0]  sum_q;

  for (genvar i = 0; i < LANES; i++) begin : g_ext
    logic [PW-1:0] p;
    assign p = data_q[STAGES-2][i*PW +: PW];
    assign lane_ext[i] = mode_q[STAGES-2] ? {{(SUM_W-PW){p[PW-1]}}, p}
                                          : {{(SUM_W-PW){1'b0}}, p};
  end

  // Adder tree over the extended lane products of slot STAGES-1.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < LANES; i++) sum_next = sum_next + lane_ext[i];
  end

  // Mode bits follow their data; the sum loads alongside the last data slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      sum_q  <= '0;
    end else if (!stall) begin
      if (accept) mode_q[0] <= bus.in_signed;
      for (int k = 1; k < STAGES-1; k++) begin
        if (valid_q[k-1]) mode_q[k] <= mode_q[k-1];
      end
      if (valid_q[STAGES-2]) sum_q <= sum_next;
    end
  end

  assign bus.out_sum = sum_q;
`endif
endmodule

// File: tb/tb_vec_mul_lanes.sv
// tb_vec_mul_lanes: directed boundary cases, backpressure streaming, full-rate random
// traffic and mid-stream reset, scored against an arithmetic reference model.
// Build with +define+VEC_MUL_SUM_EN to also score out_sum.
module tb_vec_mul_lanes;
  localparam int LANES  = 4;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int PW     = 2*WIDTH;
  localparam int PV     = LANES*PW;
  localparam int AV     = LANES*WIDTH;
  localparam int SUM_W  = PW + $clog2(LANES) + 1;

  typedef struct {
    logic [PV-1:0]    prod;
    logic [SUM_W-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  vec_mul_lanes_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  vec_mul_lanes #(.LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t          exp_q [$];
  int            compared   = 0;
  int            mismatched = 0;
  int            out_count  = 0;
  logic          accepted;
  logic [PV-1:0] last_prod;
`ifdef VEC_MUL_SUM_EN
  logic [SUM_W-1:0] last_sum;
`endif

  // Mathematical value of one operand under the chosen mode.
  function automatic longint laneValue(bit s, logic [WIDTH-1:0] v);
    longint r;
    r = longint'(v);
    if (s && v[WIDTH-1]) r = r - (longint'(1) << WIDTH);
    return r;
  endfunction

  // Reference model: exact lane products and their exact sum, reduced to port widths.
  function automatic exp_t model(bit s, logic [AV-1:0] a, logic [AV-1:0] b);
    exp_t        e;
    longint      p;
    longint      total;
    logic [63:0] bits;
    e.prod = '0;
    total  = 0;
    for (int i = 0; i < LANES; i++) begin
      p = laneValue(s, a[i*WIDTH +: WIDTH]) * laneValue(s, b[i*WIDTH +: WIDTH]);
      total = total + p;
      bits = p;
      e.prod[i*PW +: PW] = bits[PW-1:0];
    end
    bits  = total;
    e.sum = bits[SUM_W-1:0];
    return e;
  endfunction

  function automatic logic [AV-1:0] randomVec();
    logic [AV-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  task automatic checkEq(string tag, logic [127:0] obs, logic [127:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(bit v, bit s, logic [AV-1:0] a, logic [AV-1:0] b, bit ordy);
    bus.in_valid  = v;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
  endtask

  // Mid-cycle observation: handshake invariant, output scoreboard, input capture.
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst) return;
    checkEq("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
    if (bus.out_valid && bus.out_ready) begin
      out_count++;
      last_prod = bus.product;
`ifdef VEC_MUL_SUM_EN
      last_sum = bus.out_sum;
`endif
      if (exp_q.size() == 0) begin
        checkEq("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        checkEq("product", bus.product, e.prod);
`ifdef VEC_MUL_SUM_EN
        checkEq("out_sum", bus.out_sum, e.sum);
`endif
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      accepted = 1'b1;
      exp_q.push_back(model(bus.in_signed, bus.in_a, bus.in_b));
    end
  endtask

  task automatic tick();
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checkEq("drain_empty", exp_q.size(), 0);
  endtask

  // One transaction into an empty pipe: output must be absent until cycle STAGES.
  task automatic runDirected(bit s, logic [AV-1:0] a, logic [AV-1:0] b);
    last_prod = '0;
    applyStimulus(1'b1, s, a, b, 1'b1);
    tick();
    applyStimulus(1'b0, s, '0, '0, 1'b1);
    repeat (STAGES-1) begin
      @(negedge clk);
      checkEq("latency_not_yet", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    tick();
  endtask

  // Bound the whole run in case the stream stalls forever.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  logic [AV-1:0] bp_a [10];
  logic [AV-1:0] bp_b [10];
  bit            bp_s [10];

  initial begin
    int j;
    int c;
    int base;
    bit rdy_pat [4];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    checkEq("reset_out_valid", bus.out_valid, 1'b0);
    checkEq("reset_product", bus.product, '0);
    checkEq("reset_in_ready", bus.in_ready, 1'b1);
`ifdef VEC_MUL_SUM_EN
    checkEq("reset_out_sum", bus.out_sum, '0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] unsigned boundary");
    runDirected(1'b0, {LANES{8'hFF}}, {LANES{8'hFF}});
    checkEq("unsigned_ff_product", last_prod, 64'hFE01_FE01_FE01_FE01);
`ifdef VEC_MUL_SUM_EN
    checkEq("unsigned_ff_sum", last_sum, 19'h3F804);
`endif

    $display("[TB] signed boundary");
    runDirected(1'b1, {8'h00, 8'hFF, 8'h80, 8'h80}, {8'h7F, 8'h01, 8'h7F, 8'h80});
    checkEq("signed_mix_product", last_prod, 64'h0000_FFFF_C080_4000);
    runDirected(1'b1, {LANES{8'h80}}, {LANES{8'h80}});
    checkEq("signed_min_product", last_prod, 64'h4000_4000_4000_4000);
`ifdef VEC_MUL_SUM_EN
    checkEq("signed_min_sum", last_sum, 19'h10000);
`endif

    $display("[TB] backpressure stream");
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = randomVec();
      bp_b[i] = randomVec();
      bp_s[i] = 1'($urandom);
    end
    base = out_count;
    j = 0;
    c = 0;
    while (j < 10 && c < 100) begin
      applyStimulus(1'b1, bp_s[j], bp_a[j], bp_b[j], rdy_pat[c % 4]);
      tick();
      if (accepted) j++;
      c++;
    end
    checkEq("bp_all_accepted", j, 10);
    drain();
    checkEq("bp_output_count", out_count - base, 10);

    $display("[TB] full-rate random");
    base = out_count;
    for (int k = 0; k < 100 + STAGES; k++) begin
      if (k < 100) applyStimulus(1'b1, 1'($urandom), randomVec(), randomVec(), 1'b1);
      else         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      if (k < 100) checkEq("fullrate_accept", accepted, 1'b1);
      checkEq("fullrate_out_count", out_count - base, (k >= STAGES) ? (k - STAGES + 1) : 0);
    end
    drain();

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, randomVec() | AV'(1), randomVec() | AV'(1), 1'b1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, randomVec(), randomVec(), 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkEq("midreset_out_valid", bus.out_valid, 1'b0);
    checkEq("midreset_product", bus.product, '0);
    checkEq("midreset_in_ready", bus.in_ready, 1'b1);
`ifdef VEC_MUL_SUM_EN
    checkEq("midreset_out_sum", bus.out_sum, '0);
`endif
    @(posedge clk);
    #1;
    base = out_count;
    repeat (STAGES + 4) tick();
    checkEq("no_ghost_outputs", out_count - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
